// File: rtl/divider_pkg.sv
// Shared widths, state encoding and constants for the sequential restoring divider.
package divider_pkg;

    localparam int DW_N = 8;
    localparam int DW_D = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Quotient reported when the divisor is zero.
    localparam logic [DW_N-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/divider_s_if.sv
// Operand/result handshake between a requester and the divider.
interface divider_s_if #(
    parameter int DW_N = divider_pkg::DW_N,
    parameter int DW_D = divider_pkg::DW_D
);

    logic            start;
    logic [DW_N-1:0] dividend;
    logic [DW_D-1:0] divisor;
    logic            busy;
    logic            done;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;
    logic            div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int DW_D = divider_pkg::DW_D
) (
    input  logic [DW_D-1:0] r,
    input  logic            bit_in,
    input  logic [DW_D-1:0] divisor,
    output logic [DW_D-1:0] r_next,
    output logic            q_bit
);

    logic [DW_D:0] trial;

    assign trial = {r, bit_in};

    // The result is always below the divisor, so DW_D bits hold it without loss.
    always_comb begin
        r_next = trial[DW_D-1:0];
        q_bit  = 1'b0;
        if (trial >= {1'b0, divisor}) begin
            r_next = DW_D'(trial - {1'b0, divisor});
            q_bit  = 1'b1;
        end
    end

endmodule

// File: rtl/divider_s.sv
// Sequential restoring divider: one quotient bit per clock, busy/done handshake.
module divider_s
    import divider_pkg::*;
#(
    parameter int DW_N = divider_pkg::DW_N,
    parameter int DW_D = divider_pkg::DW_D
) (
    input logic        clk,
    input logic        rst,
    divider_s_if.slave bus
);

    localparam int CW = $clog2(DW_N);

    state_t          state;
    state_t          next_state;
    logic [DW_N-1:0] shreg;
    logic [DW_D-1:0] r;
    logic [DW_D-1:0] divisor_q;
    logic [CW-1:0]   cnt;
    logic [DW_N-1:0] quotient_q;
    logic [DW_D-1:0] remainder_q;
    logic            div_by_zero_q;
    logic            accept;
    logic            zero_div;
    logic            last_step;
    logic [DW_D-1:0] r_next;
    logic            q_bit;

    div_step #(.DW_D(DW_D)) u_step (
        .r       (r),
        .bit_in  (shreg[DW_N-1]),
        .divisor (divisor_q),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    assign accept    = bus.start && (state != CALC);
    assign zero_div  = (bus.divisor == '0);
    assign last_step = (state == CALC) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    next_state = zero_div ? DONE : CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Results only move on the edge that raises done; a zero divisor skips CALC entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg         <= '0;
            r             <= '0;
            divisor_q     <= '0;
            cnt           <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else if (accept) begin
            if (zero_div) begin
                quotient_q    <= DIV0_QUOTIENT;
                remainder_q   <= '0;
                div_by_zero_q <= 1'b1;
            end else begin
                shreg     <= bus.dividend;
                r         <= '0;
                cnt       <= CW'(DW_N - 1);
                divisor_q <= bus.divisor;
            end
        end else if (state == CALC) begin
            shreg <= {shreg[DW_N-2:0], q_bit};
            r     <= r_next;
            cnt   <= cnt - 1'b1;
            if (last_step) begin
                quotient_q    <= {shreg[DW_N-2:0], q_bit};
                remainder_q   <= r_next;
                div_by_zero_q <= 1'b0;
            end
        end
    end

    assign bus.busy        = (state == CALC);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_divider_s.sv
// Scoreboard bench for divider_s: operands queued at start, checked against / and % at done.
module tb_divider_s;

    logic clk = 1'b0;
    logic rst;

    divider_s_if bus ();

    divider_s dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] dividend;
        logic [3:0] divisor;
    } op_t;

    op_t sb[$];
    int  compareCount  = 0;
    int  mismatchCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b, input bit track);
        op_t op;
        op.dividend  = a;
        op.divisor   = b;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        if (track) sb.push_back(op);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic waitDone(output int n, output int busyN);
        n     = 0;
        busyN = 0;
        while (!bus.done && n < 20) begin
            busyN += int'(bus.busy);
            tick();
            n++;
        end
        if (!bus.done) checkOutput("done_timeout", 32'(bus.done), 1);
    endtask

    // Every done pulse retires exactly one queued operation.
    always @(posedge clk) begin
        op_t op;
        #1;
        if (bus.done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'(bus.done), 0);
            end else begin
                op = sb.pop_front();
                checkOutput("busy_at_done", 32'(bus.busy), 0);
                if (op.divisor == 4'd0) begin
                    checkOutput("div0_quotient", 32'(bus.quotient), 255);
                    checkOutput("div0_remainder", 32'(bus.remainder), 0);
                    checkOutput("div0_flag", 32'(bus.div_by_zero), 1);
                end else begin
                    checkOutput("quotient", 32'(bus.quotient), 32'(op.dividend) / 32'(op.divisor));
                    checkOutput("remainder", 32'(bus.remainder), 32'(op.dividend) % 32'(op.divisor));
                    checkOutput("div0_flag", 32'(bus.div_by_zero), 0);
                    checkOutput("invariant",
                                32'(bus.quotient) * 32'(op.divisor) + 32'(bus.remainder),
                                32'(op.dividend));
                    checkOutput("rem_lt_div", 32'(bus.remainder < op.divisor), 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int n2;
        int busyN;
        int doneSeen;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        tick();
        tick();
        checkOutput("reset_busy", 32'(bus.busy), 0);
        checkOutput("reset_done", 32'(bus.done), 0);
        checkOutput("reset_quotient", 32'(bus.quotient), 0);
        checkOutput("reset_remainder", 32'(bus.remainder), 0);
        checkOutput("reset_div0", 32'(bus.div_by_zero), 0);
        rst = 1'b0;
        tick();

        $display("[TB] 100 / 7");
        applyStimulus(8'd100, 4'd7, 1'b1);
        checkOutput("t1_busy_after_accept", 32'(bus.busy), 1);
        waitDone(n, busyN);
        checkOutput("t1_latency", n, 8);
        checkOutput("t1_busy_cycles", busyN, 8);
        tick();

        $display("[TB] 255 / 1 then 5 / 9 back-to-back");
        applyStimulus(8'd255, 4'd1, 1'b1);
        waitDone(n, busyN);
        checkOutput("t2_first_latency", n, 8);
        applyStimulus(8'd5, 4'd9, 1'b1);
        checkOutput("t2_done_drops", 32'(bus.done), 0);
        waitDone(n2, busyN);
        checkOutput("t2_done_spacing", n2 + 1, 9);
        tick();

        $display("[TB] 200 / 0");
        applyStimulus(8'd200, 4'd0, 1'b1);
        waitDone(n, busyN);
        checkOutput("t3_extra_edges", n, 0);
        checkOutput("t3_busy_cycles", busyN, 0);
        tick();
        checkOutput("t3_busy_after", 32'(bus.busy), 0);

        $display("[TB] 225 / 15 with ignored restart");
        applyStimulus(8'd225, 4'd15, 1'b1);
        tick();
        tick();
        bus.dividend = 8'd9;
        bus.divisor  = 4'd3;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        waitDone(n, busyN);
        checkOutput("t4_latency", n + 3, 8);
        doneSeen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            doneSeen += int'(bus.done);
        end
        checkOutput("t4_no_extra_done", doneSeen, 0);

        $display("[TB] 150 / 11 aborted by reset");
        applyStimulus(8'd150, 4'd11, 1'b0);
        tick();
        tick();
        tick();
        rst          = 1'b1;
        bus.start    = 1'b1;
        tick();
        checkOutput("t5_quotient", 32'(bus.quotient), 0);
        checkOutput("t5_remainder", 32'(bus.remainder), 0);
        checkOutput("t5_div0", 32'(bus.div_by_zero), 0);
        checkOutput("t5_busy", 32'(bus.busy), 0);
        checkOutput("t5_done", 32'(bus.done), 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        doneSeen  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            doneSeen += int'(bus.done) + int'(bus.busy);
        end
        checkOutput("t5_idle_after_reset", doneSeen, 0);
        applyStimulus(8'd150, 4'd11, 1'b1);
        waitDone(n, busyN);
        checkOutput("t5_latency", n, 8);
        tick();

        $display("[TB] exhaustive sweep");
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                applyStimulus(8'(a), 4'(b), 1'b1);
                waitDone(n, busyN);
            end
        end
        tick();
        tick();
        checkOutput("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/divider_s.md
# divider_s

Sequential restoring divider: unsigned 8-bit dividend ÷ 4-bit divisor, producing 8-bit quotient and 4-bit remainder, one quotient bit per clock. It is the inverse companion to the team's 4-bit array multiplier. It uses the same start-driven operand capture and registered-result style, adds a busy/done handshake, and is intended for checking products by division (dividend = product, divisor = one factor).

## Interface
- DW_N, 8: dividend and quotient width.
- DW_D, 4: divisor and remainder width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request. Sampled only in IDLE or DONE.
- dividend  in  DW_N  unsigned dividend. Captured on an accepted start.
- divisor  in  DW_D  unsigned divisor. Captured on an accepted start.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse. Results are valid from this cycle on.
- quotient  out  DW_N  registered quotient. Held until the next done.
- remainder  out  DW_D  registered remainder. Held until the next done.
- div_by_zero  out  1  registered flag, updated together with done.

## Operation
- One clock, synchronous active-high reset; no asynchronous logic.
- States:
  - IDLE: waits for start.
  - CALC: iterates.
  - DONE: one cycle, pulses done.
- IDLE/DONE with start=1 and divisor≠0:
  - Load the shift register with dividend.
  - Clear the partial remainder (DW_D+1 bits).
  - Set the bit counter to DW_N-1.
  - Go to CALC.
- IDLE/DONE with start=1 and divisor=0:
  - Go to DONE directly.
  - quotient=all ones, remainder=0, div_by_zero=1.
- CALC, each cycle:
  - r' = {r[DW_D-1:0], shreg MSB}.
  - If r' ≥ {0,divisor}: r = r' − divisor and shift 1 into the shreg LSB. Otherwise: r = r' and shift 0 in.
  - When the counter reaches 0: go to DONE, quotient = shreg (final), remainder = r[DW_D-1:0], div_by_zero=0.
  - Otherwise the counter decrements.
- DONE with no start: go to IDLE.
- start in CALC is ignored. No queueing, and the operands are not re-captured.
- Arithmetic is unsigned throughout. The partial remainder always stays < divisor, so it fits in DW_D bits at completion.
- Invariant: dividend = quotient·divisor + remainder, with remainder < divisor, whenever divisor≠0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Internal registers are also cleared.
- Start accepted at edge E0 → busy=1 after E0. CALC spans edges E1..E8 (DW_N edges).
- done=1 and results are valid after edge E8, and busy drops after the same edge. Latency is DW_N cycles from the accepting edge.
- Divide-by-zero: done=1 after E0, so latency is 1 cycle. busy never asserts.
- Back-to-back: start high during the DONE cycle is accepted. done falls, busy rises, and the new operation follows the same timing, giving throughput of one result per DW_N+1 cycles.
- rst high at any edge overrides everything, including mid-CALC. The state returns to IDLE with the reset values above. A start in the same cycle as rst is dropped.
- quotient/remainder/div_by_zero change only on the edge that asserts done, or on reset.

## Structure
- Package divider_pkg holds:
  - the DW_N/DW_D defaults;
  - the state enum (IDLE, CALC, DONE);
  - the divide-by-zero quotient constant (all ones).
- Sub-module div_step: combinational one-bit restoring step. Inputs are r, the incoming bit and the divisor; outputs are next r and the quotient bit. It is instantiated once inside divider_s.
- The counter width is $clog2(DW_N).

## Test plan
- 100 ÷ 7, start pulse → done exactly 8 cycles after acceptance; quotient=14, remainder=2, div_by_zero=0; busy high for 8 cycles.
- 255 ÷ 1 then 5 ÷ 9, the second start issued in the DONE cycle → quotient=255, remainder=0; then quotient=0, remainder=5; done pulses 9 cycles apart.
- 200 ÷ 0 → done 1 cycle after start; quotient=0xFF, remainder=0, div_by_zero=1; busy stays 0.
- 225 ÷ 15, with start re-pulsed at CALC cycle 3 using operands 9 ÷ 3 → the second start is ignored; the result is quotient=15, remainder=0.
- 150 ÷ 11, rst asserted at CALC cycle 4 → all outputs read 0, the state is IDLE, no done pulse. A following start with 150 ÷ 11 yields quotient=13, remainder=7.
- Exhaustive sweep, dividend 0..255 × divisor 1..15, against a reference model → every case satisfies the quotient·divisor + remainder invariant with remainder < divisor.
